// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and result-register FSM state encodings
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_B_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_LOAD         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with synchronous reset to a fixed level
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values simply shift the raw input down the two-stage chain
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Both stages reset to the idle level so a released key reads as released
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/alu_result_reg.sv
// rtl/alu_result_reg.sv - debounced push-button capture of the ALU result with B feedback
module alu_result_reg
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DATA_W          = ALU_DATA_W,
  parameter int B_W             = ALU_B_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              KEY_n,
  input  logic [DATA_W-1:0] ALUIn,
  output logic [DATA_W-1:0] Q,
  output logic [B_W-1:0]    BOut,
  output logic              LoadPulse,
  output logic              Busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic key_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              load_pulse_q, load_pulse_d;

  sync2 #(.RESET_VAL(1'b1)) u_key_sync (
    .clk (Clock),
    .rst (Reset),
    .d   (KEY_n),
    .q   (key_s)
  );

  // Press/release qualification; the result register only moves in LOAD
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_d          = q_q;
    load_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (key_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        q_d          = ALUIn;
        load_pulse_d = 1'b1;
        cnt_d        = '0;
        state_d      = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!key_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and result register; reset clears Q rather than holding it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      q_q          <= '0;
      load_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_q          <= q_d;
      load_pulse_q <= load_pulse_d;
    end
  end

  assign Q         = q_q;
  assign BOut      = q_q[B_W-1:0];
  assign LoadPulse = load_pulse_q;
  assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_result_reg.sv
// tb/tb_alu_result_reg.sv - directed vector bench for alu_result_reg with DEBOUNCE_CYCLES=4
module tb_alu_result_reg;

  logic       Clock;
  logic       Reset;
  logic       KEY_n;
  logic [7:0] ALUIn;
  logic [7:0] Q;
  logic [3:0] BOut;
  logic       LoadPulse;
  logic       Busy;

  int tests;
  int failed;

  typedef struct {
    logic       key_n;
    logic [7:0] alu;
    logic       rst;
    logic [7:0] q;
    logic       lp;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  alu_result_reg #(
    .DEBOUNCE_CYCLES(4),
    .DATA_W         (8),
    .B_W            (4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .KEY_n    (KEY_n),
    .ALUIn    (ALUIn),
    .Q        (Q),
    .BOut     (BOut),
    .LoadPulse(LoadPulse),
    .Busy     (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic add(input logic k, input logic [7:0] a, input logic r,
                     input logic [7:0] eq, input logic elp, input logic ebusy);
    vec_t v;
    v.key_n = k;
    v.alu   = a;
    v.rst   = r;
    v.q     = eq;
    v.lp    = elp;
    v.busy  = ebusy;
    vecs.push_back(v);
  endtask

  task automatic step(input logic k, input logic [7:0] a, input logic r);
    KEY_n = k;
    ALUIn = a;
    Reset = r;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] eq,
                       input logic elp, input logic ebusy);
    logic [3:0] eb;
    eb = eq[3:0];
    tests++;
    if (Q !== eq || BOut !== eb || LoadPulse !== elp || Busy !== ebusy) begin
      failed++;
      $display("FAIL %s[%0d]: got Q=%h BOut=%h LoadPulse=%b Busy=%b, expected Q=%h BOut=%h LoadPulse=%b Busy=%b",
               name, idx, Q, BOut, LoadPulse, Busy, eq, eb, elp, ebusy);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    KEY_n  = 1'b1;
    ALUIn  = 8'hAA;
    Reset  = 1'b1;

    // reset with garbage on ALUIn
    for (int i = 0; i < 2; i++) add(1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0);
    // clean press held 30 cycles: load at edge 8 only
    for (int k = 1; k <= 30; k++)
      add(1'b0, 8'h0F, 1'b0, (k >= 8) ? 8'h0F : 8'h00, k == 8, k >= 3);
    // release with one low bounce: idle 4 edges after stable high reaches key_s
    for (int r = 1; r <= 13; r++)
      add((r == 3) ? 1'b0 : 1'b1, 8'h0F, 1'b0, 8'h0F, 1'b0, r <= 8);
    // next press loads zero
    for (int k = 1; k <= 10; k++)
      add(1'b0, 8'h00, 1'b0, (k >= 8) ? 8'h00 : 8'h0F, k == 8, k >= 3);
    // clean release
    for (int e = 1; e <= 8; e++)
      add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, e <= 5);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].key_n, vecs[i].alu, vecs[i].rst);
      check("table", i, vecs[i].q, vecs[i].lp, vecs[i].busy);
    end

    // bounce rejection: low runs of 2 never qualify
    for (int rep = 0; rep < 10; rep++) begin
      for (int j = 1; j <= 6; j++) begin
        step((j <= 2) ? 1'b0 : 1'b1, 8'h55, 1'b0);
        check("bounce", rep * 6 + j, 8'h00, 1'b0, (j == 3) || (j == 4));
      end
    end

    // ALUIn change during debounce is picked up; change after load is ignored
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, (k >= 9) ? 8'hAA : ((k >= 6) ? 8'h0F : 8'h00), 1'b0);
      check("middata", k, (k >= 8) ? 8'h0F : 8'h00, k == 8, k >= 3);
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 8'hAA, 1'b0);
      check("middata_rel", e, 8'h0F, 1'b0, e <= 5);
    end

    // reset at edge 5 of a held press clears Q, then the held key reloads
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 8'h3C, k == 5);
      check("midreset", k, (k == 5) ? 8'h00 : 8'h0F, 1'b0, (k >= 3) && (k < 5));
    end
    for (int f = 1; f <= 10; f++) begin
      step(1'b0, 8'h3C, 1'b0);
      check("reload", f, (f >= 8) ? 8'h3C : 8'h00, f == 8, f >= 3);
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 8'h3C, 1'b0);
      check("reload_rel", e, 8'h3C, 1'b0, e <= 5);
    end

    // reset on the load edge wins
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h77, k == 8);
      check("rst_load", k, (k == 8) ? 8'h00 : 8'h3C, 1'b0, (k >= 3) && (k < 8));
    end
    for (int f = 1; f <= 6; f++) begin
      step(1'b1, 8'h77, 1'b0);
      check("rst_load_after", f, 8'h00, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
